// File: rtl/conv_sched_if.sv
// Handshake and index bundle between layer control / weight loader / PE array
// and the convolution loop-nest scheduler.
interface conv_sched_if;
  logic       start;
  logic       busy;
  logic       done;
  logic [7:0] k_idx;
  logic [7:0] cha_idx;
  logic [7:0] row_idx;
  logic [7:0] col_idx;
  logic       wt_req;
  logic       wt_ack;
  logic       pe_ready;
  logic       fetch_en;
  logic       acc_first;
  logic       acc_last;
  logic       pe_idle;

  modport master (
    output start, wt_ack, pe_ready, pe_idle,
    input  busy, done, k_idx, cha_idx, row_idx, col_idx,
    input  wt_req, fetch_en, acc_first, acc_last
  );

  modport slave (
    input  start, wt_ack, pe_ready, pe_idle,
    output busy, done, k_idx, cha_idx, row_idx, col_idx,
    output wt_req, fetch_en, acc_first, acc_last
  );
endinterface

// File: rtl/conv_sched.sv
// Loop-nest scheduler: kernel / channel / row / column counters with a weight
// handshake per (kernel, channel), back-pressured column streaming and a drain.
module conv_sched #(
  parameter int K    = 8,
  parameter int WCHA = 3,
  parameter int ROW  = 32,
  parameter int COL  = 32
) (
  input  logic         clk,
  input  logic         rst,
  conv_sched_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE,
    WLOAD,
    STREAM,
    DRAIN,
    DONE
  } state_t;

  localparam logic [7:0] K_LAST   = 8'(K - 1);
  localparam logic [7:0] CHA_LAST = 8'(WCHA - 1);
  localparam logic [7:0] ROW_LAST = 8'(ROW - 1);
  localparam logic [7:0] COL_LAST = 8'(COL - 1);

  state_t     state;
  logic [7:0] k_idx;
  logic [7:0] cha_idx;
  logic [7:0] row_idx;
  logic [7:0] col_idx;
  logic       fetch;

  // NOTE: reset is sampled inside the clocked block, so it only takes effect on
  // a rising edge; every register here uses non-blocking assignment so all
  // counters see the pre-edge values of each other.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      k_idx   <= '0;
      cha_idx <= '0;
      row_idx <= '0;
      col_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state   <= WLOAD;
            k_idx   <= '0;
            cha_idx <= '0;
            row_idx <= '0;
            col_idx <= '0;
          end
        end

        WLOAD: begin
          if (bus.wt_ack) state <= STREAM;
        end

        STREAM: begin
          if (bus.pe_ready) begin
            if (col_idx == COL_LAST) begin
              col_idx <= '0;
              if (row_idx == ROW_LAST) begin
                row_idx <= '0;
                state   <= DRAIN;
              end else begin
                row_idx <= row_idx + 8'd1;
              end
            end else begin
              col_idx <= col_idx + 8'd1;
            end
          end
        end

        DRAIN: begin
          if (bus.pe_idle) begin
            if (cha_idx != CHA_LAST) begin
              cha_idx <= cha_idx + 8'd1;
              state   <= WLOAD;
            end else begin
              cha_idx <= '0;
              if (k_idx != K_LAST) begin
                k_idx <= k_idx + 8'd1;
                state <= WLOAD;
              end else begin
                state <= DONE;
              end
            end
          end
        end

        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Fetch strobes stay combinational on pe_ready so a column issues the same
  // cycle the PE array signals room for it.
  assign fetch = (state == STREAM) && bus.pe_ready;

  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == DONE);
  assign bus.wt_req    = (state == WLOAD);
  assign bus.fetch_en  = fetch;
  assign bus.acc_first = fetch && (cha_idx == 8'd0);
  assign bus.acc_last  = fetch && (cha_idx == CHA_LAST);
  assign bus.k_idx     = k_idx;
  assign bus.cha_idx   = cha_idx;
  assign bus.row_idx   = row_idx;
  assign bus.col_idx   = col_idx;

endmodule
